// File: rtl/oled_text_sequencer_if.sv
// Host and driver-side signal bundle for oled_text_sequencer.
// The slave modport is the sequencer's view. The master modport is the
// surrounding logic (host writers plus the OLED driver command port).
interface oled_text_sequencer_if;
    // Host-side text writes and requests
    logic       wr_en;
    logic [1:0] wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_char;
    logic       flush;
    logic       clear_req;
    logic       bmp_req;
    logic [1:0] bmp_sel;
    logic       busy;
    logic [6:0] pending_cnt;
    // Driver command port
    logic       drv_showchar;
    logic       drv_showbmp;
    logic       drv_clear;
    logic [7:0] drv_charval;
    logic [1:0] drv_row;
    logic [3:0] drv_col;
    logic [1:0] drv_bmp;
    logic       drv_ready;

    modport slave (
        input  wr_en, wr_row, wr_col, wr_char, flush, clear_req, bmp_req, bmp_sel, drv_ready,
        output busy, pending_cnt, drv_showchar, drv_showbmp, drv_clear,
               drv_charval, drv_row, drv_col, drv_bmp
    );

    modport master (
        output wr_en, wr_row, wr_col, wr_char, flush, clear_req, bmp_req, bmp_sel, drv_ready,
        input  busy, pending_cnt, drv_showchar, drv_showbmp, drv_clear,
               drv_charval, drv_row, drv_col, drv_bmp
    );
endinterface

// File: rtl/oled_text_sequencer.sv
// Text sequencer in front of the OLED driver: a 4x16 shadow buffer with
// per-cell dirty bits, sticky clear/bitmap/flush requests and a one-command-
// at-a-time issue engine built around the driver's ready handshake.
module oled_text_sequencer #(
    parameter int         ACK_TIMEOUT = 1024,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    oled_text_sequencer_if.slave bus
);
    localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;
    typedef enum logic [1:0] {CMD_CHAR, CMD_CLEAR, CMD_BMP} cmd_t;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [5:0]    ptr_q, ptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          clr_pend_q, clr_pend_d;
    logic          bmp_pend_q, bmp_pend_d;
    logic          flush_pend_q, flush_pend_d;
    logic [1:0]    bmp_sel_q, bmp_sel_d;
    logic [1:0]    issue_bmp_q, issue_bmp_d;
    logic [63:0]   dirty_q, dirty_d;
    logic [7:0]    cells_q [64];
    logic [7:0]    cells_d [64];
    logic [6:0]    pending_cnt_q, pending_cnt_d;
    logic [7:0]    charval_q, charval_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    bmp_q, bmp_d;

    logic [5:0] wr_idx;
    logic       idle_ready, take_clr, take_bmp, take_flush, pulse, complete;

    // Decode arbitration winners, the command pulse and command completion.
    always_comb begin
        wr_idx     = {bus.wr_row, bus.wr_col};
        idle_ready = (state_q == S_IDLE) && bus.drv_ready;
        take_clr   = idle_ready && clr_pend_q;
        take_bmp   = idle_ready && !clr_pend_q && bmp_pend_q;
        take_flush = idle_ready && !clr_pend_q && !bmp_pend_q && flush_pend_q;
        pulse      = (state_q == S_ISSUE) && bus.drv_ready;
        // A WAIT_ACK that runs out of time is treated like a finished command.
        complete   = bus.drv_ready &&
                     ((state_q == S_WAIT_DONE) || ((state_q == S_WAIT_ACK) && (tmo_q == TMO_LAST)));
    end

    // Next-state, buffer/dirty updates, request flags and held driver operands.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        ptr_d         = ptr_q;
        tmo_d         = tmo_q;
        issue_bmp_d   = issue_bmp_q;
        dirty_d       = dirty_q;
        cells_d       = cells_q;
        charval_d     = charval_q;
        row_d         = row_q;
        col_d         = col_q;
        bmp_d         = bmp_q;
        pending_cnt_d = 7'($countones(dirty_q));

        // A new request in the cycle its flag is taken re-arms the flag.
        clr_pend_d   = (clr_pend_q   && !take_clr)   || bus.clear_req;
        bmp_pend_d   = (bmp_pend_q   && !take_bmp)   || bus.bmp_req;
        flush_pend_d = (flush_pend_q && !take_flush) || bus.flush;
        bmp_sel_d    = bus.bmp_req ? bus.bmp_sel : bmp_sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (take_clr) begin
                    cmd_d   = CMD_CLEAR;
                    state_d = S_ISSUE;
                end else if (take_bmp) begin
                    cmd_d       = CMD_BMP;
                    issue_bmp_d = bmp_sel_q;
                    state_d     = S_ISSUE;
                end else if (take_flush) begin
                    ptr_d   = 6'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (dirty_q[ptr_q]) begin
                    cmd_d   = CMD_CHAR;
                    state_d = S_ISSUE;
                end else if (ptr_q == 6'd63) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + 6'd1;
                end
            end
            S_ISSUE: begin
                if (pulse) begin
                    if (cmd_q == CMD_CHAR) begin
                        dirty_d[ptr_q] = 1'b0;
                    end
                    tmo_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!bus.drv_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q != TMO_LAST) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: ;
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            unique case (cmd_q)
                CMD_CLEAR: begin
                    for (int i = 0; i < 64; i++) begin
                        cells_d[i] = BLANK_CHAR;
                    end
                    dirty_d = '0;
                    state_d = S_IDLE;
                end
                CMD_BMP: begin
                    // The bitmap overwrote the panel, so all text must be redrawn.
                    dirty_d = '1;
                    state_d = S_IDLE;
                end
                default: begin
                    if (ptr_q == 6'd63) begin
                        state_d = S_IDLE;
                    end else begin
                        ptr_d   = ptr_q + 6'd1;
                        state_d = S_SCAN;
                    end
                end
            endcase
        end

        // Host writes land last so they win over the clear fill and the
        // dirty-bit clear of the cell being issued.
        if (bus.wr_en) begin
            cells_d[wr_idx] = bus.wr_char;
            dirty_d[wr_idx] = 1'b1;
        end

        if (pulse && (cmd_q == CMD_CHAR)) begin
            charval_d = cells_q[ptr_q];
            row_d     = ptr_q[5:4];
            col_d     = ptr_q[3:0];
        end
        if (pulse && (cmd_q == CMD_BMP)) begin
            bmp_d = issue_bmp_q;
        end
    end

    // State, request and operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cmd_q         <= CMD_CHAR;
            ptr_q         <= '0;
            tmo_q         <= '0;
            clr_pend_q    <= 1'b0;
            bmp_pend_q    <= 1'b0;
            flush_pend_q  <= 1'b0;
            bmp_sel_q     <= '0;
            issue_bmp_q   <= '0;
            dirty_q       <= '0;
            pending_cnt_q <= '0;
            charval_q     <= '0;
            row_q         <= '0;
            col_q         <= '0;
            bmp_q         <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            ptr_q         <= ptr_d;
            tmo_q         <= tmo_d;
            clr_pend_q    <= clr_pend_d;
            bmp_pend_q    <= bmp_pend_d;
            flush_pend_q  <= flush_pend_d;
            bmp_sel_q     <= bmp_sel_d;
            issue_bmp_q   <= issue_bmp_d;
            dirty_q       <= dirty_d;
            pending_cnt_q <= pending_cnt_d;
            charval_q     <= charval_d;
            row_q         <= row_d;
            col_q         <= col_d;
            bmp_q         <= bmp_d;
        end
    end

    // Character shadow buffer; reset fills every cell with the blank code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                cells_q[i] <= BLANK_CHAR;
            end
        end else begin
            cells_q <= cells_d;
        end
    end

    // Pulses are gated by drv_ready in ISSUE; operands are live during the
    // pulse and otherwise hold the values of the previous pulse.
    assign bus.busy         = (state_q != S_IDLE) || clr_pend_q || bmp_pend_q || flush_pend_q;
    assign bus.pending_cnt  = pending_cnt_q;
    assign bus.drv_showchar = pulse && (cmd_q == CMD_CHAR);
    assign bus.drv_clear    = pulse && (cmd_q == CMD_CLEAR);
    assign bus.drv_showbmp  = pulse && (cmd_q == CMD_BMP);
    assign bus.drv_charval  = charval_d;
    assign bus.drv_row      = row_d;
    assign bus.drv_col      = col_d;
    assign bus.drv_bmp      = bmp_d;
endmodule

// File: tb/tb_oled_text_sequencer.sv
// Self-checking bench for oled_text_sequencer: a behavioural buffer model
// pushes expected driver commands to a queue, a negedge monitor pops them.
module tb_oled_text_sequencer;
    localparam int         ACK_TIMEOUT = 40;
    localparam logic [7:0] BLANK       = 8'h20;
    localparam logic [1:0] K_CHAR = 2'd0, K_CLEAR = 2'd1, K_BMP = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] row;
        logic [3:0] col;
        logic [7:0] ch;
        logic [1:0] bmp;
    } cmd_t;

    typedef struct packed {
        logic [1:0] row;
        logic [3:0] col;
        logic [7:0] ch;
        logic [6:0] exp_cnt;
        logic       flush_after;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oled_text_sequencer_if bus_if();

    oled_text_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .BLANK_CHAR(BLANK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int         tests = 0;
    int         fails = 0;
    cmd_t       exp_q[$];
    logic [7:0] exp_buf [64];
    logic       exp_dirty [64];
    logic       stuck = 1'b0;
    int         bcnt;
    cmd_t       mon_got, mon_exp;
    logic       any_pulse;

    assign any_pulse = bus_if.drv_showchar || bus_if.drv_showbmp || bus_if.drv_clear;

    // Driver model: busy for 5 cycles after each command, or never (stuck).
    always @(posedge clk or posedge rst) begin
        if (rst) bcnt <= 0;
        else if (any_pulse && !stuck) bcnt <= 5;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign bus_if.drv_ready = (bcnt == 0);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every command pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst && any_pulse) begin
            check("one pulse per cycle",
                  32'(bus_if.drv_showchar) + 32'(bus_if.drv_showbmp) + 32'(bus_if.drv_clear), 1);
            mon_got = '0;
            if (bus_if.drv_clear) begin
                mon_got.kind = K_CLEAR;
            end else if (bus_if.drv_showbmp) begin
                mon_got.kind = K_BMP;
                mon_got.bmp  = bus_if.drv_bmp;
            end else begin
                mon_got.kind = K_CHAR;
                mon_got.row  = bus_if.drv_row;
                mon_got.col  = bus_if.drv_col;
                mon_got.ch   = bus_if.drv_charval;
            end
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected command: got %h, expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("driver command", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    function automatic cmd_t mk(input logic [1:0] k, input logic [5:0] idx,
                                input logic [7:0] ch, input logic [1:0] b);
        cmd_t c;
        c = '0;
        c.kind = k;
        if (k == K_CHAR) begin
            c.row = idx[5:4];
            c.col = idx[3:0];
            c.ch  = ch;
        end
        if (k == K_BMP) c.bmp = b;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            exp_buf[i]   = BLANK;
            exp_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 64; i++) begin
            if (exp_dirty[i]) begin
                exp_q.push_back(mk(K_CHAR, 6'(i), exp_buf[i], 2'd0));
                exp_dirty[i] = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        exp_q.push_back(mk(K_CLEAR, 6'd0, 8'd0, 2'd0));
        model_reset();
    endtask

    task automatic model_bmp(input logic [1:0] b);
        exp_q.push_back(mk(K_BMP, 6'd0, 8'd0, b));
        for (int i = 0; i < 64; i++) exp_dirty[i] = 1'b1;
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic host_write(input logic [1:0] r, input logic [3:0] c, input logic [7:0] ch);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_row  = r;
        bus_if.wr_col  = c;
        bus_if.wr_char = ch;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        exp_buf[{r, c}]   = ch;
        exp_dirty[{r, c}] = 1'b1;
    endtask

    task automatic req(input logic c, input logic b, input logic [1:0] sel, input logic f);
        bus_if.clear_req = c;
        bus_if.bmp_req   = b;
        bus_if.bmp_sel   = sel;
        bus_if.flush     = f;
        @(negedge clk);
        bus_if.clear_req = 1'b0;
        bus_if.bmp_req   = 1'b0;
        bus_if.flush     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus_if.busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, " reaches idle"}, 32'(bus_if.busy), 0);
        check({name, " scoreboard drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_pulse(input string name, input logic want_clear, output logic found);
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            if (want_clear ? bus_if.drv_clear : bus_if.drv_showchar) found = 1'b1;
            else @(negedge clk);
        end
        check({name, " pulse seen"}, 32'(found), 1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!bus_if.busy) break;
            n++;
        end
    endtask

    vec_t vecs[6];
    int   n;
    logic found;

    initial begin
        vecs[0] = '{2'd1, 4'd3,  8'h41, 7'd1, 1'b0};
        vecs[1] = '{2'd3, 4'd15, 8'h42, 7'd2, 1'b1};
        vecs[2] = '{2'd0, 4'd0,  8'h78, 7'd1, 1'b0};
        vecs[3] = '{2'd2, 4'd7,  8'h79, 7'd2, 1'b0};
        vecs[4] = '{2'd0, 4'd0,  8'h7a, 7'd2, 1'b0};
        vecs[5] = '{2'd3, 4'd0,  8'h77, 7'd3, 1'b1};

        bus_if.wr_en = 1'b0; bus_if.wr_row = '0; bus_if.wr_col = '0; bus_if.wr_char = '0;
        bus_if.flush = 1'b0; bus_if.clear_req = 1'b0; bus_if.bmp_req = 1'b0; bus_if.bmp_sel = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(bus_if.busy), 0);
        check("reset pending_cnt", 32'(bus_if.pending_cnt), 0);
        check("reset pulses", 32'({bus_if.drv_showchar, bus_if.drv_showbmp, bus_if.drv_clear}), 0);
        check("reset operands", 32'({bus_if.drv_charval, bus_if.drv_row, bus_if.drv_col, bus_if.drv_bmp}), 0);

        // Table-driven writes and flushes; flush rows are the highest dirty index.
        for (int i = 0; i < 6; i++) begin
            host_write(vecs[i].row, vecs[i].col, vecs[i].ch);
            @(negedge clk);
            check("pending_cnt after write", 32'(bus_if.pending_cnt), 32'(vecs[i].exp_cnt));
            if (vecs[i].flush_after) begin
                model_flush();
                req(1'b0, 1'b0, 2'd0, 1'b1);
                wait_idle("table flush");
                check("pending_cnt after flush", 32'(bus_if.pending_cnt), 0);
                check("operands held after flush",
                      32'({bus_if.drv_row, bus_if.drv_col, bus_if.drv_charval}),
                      32'({vecs[i].row, vecs[i].col, vecs[i].ch}));
            end
        end

        // Flush with nothing dirty: one latch cycle plus 64 SCAN cycles.
        req(1'b0, 1'b0, 2'd0, 1'b1);
        n = 0;
        while (bus_if.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("empty flush busy cycles", n, 65);

        // clear + bmp together while a flush is also pending.
        host_write(2'd2, 4'd5, 8'h51);
        model_clear();
        model_bmp(2'd2);
        model_flush();
        req(1'b1, 1'b1, 2'd2, 1'b1);
        wait_idle("clear/bmp/flush");
        check("pending_cnt after full redraw", 32'(bus_if.pending_cnt), 0);
        model_clear();
        model_bmp(2'd2);
        req(1'b1, 1'b1, 2'd2, 1'b0);
        wait_idle("clear/bmp");
        check("pending_cnt after bmp", 32'(bus_if.pending_cnt), 64);
        check("drv_bmp held", 32'(bus_if.drv_bmp), 2);
        model_flush();
        req(1'b0, 1'b0, 2'd0, 1'b1);
        wait_idle("flush after bmp");
        check("pending_cnt after blank redraw", 32'(bus_if.pending_cnt), 0);

        // Host write to the cell in its ISSUE cycle keeps the dirty bit.
        host_write(2'd2, 4'd4, 8'h4d);
        host_write(2'd2, 4'd9, 8'h4e);
        model_flush();
        req(1'b0, 1'b0, 2'd0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (bus_if.drv_showchar && bus_if.drv_row == 2'd2 && bus_if.drv_col == 4'd4) found = 1'b1;
            else @(negedge clk);
        end
        check("issue-cycle pulse seen", 32'(found), 1);
        bus_if.wr_en = 1'b1; bus_if.wr_row = 2'd2; bus_if.wr_col = 4'd4; bus_if.wr_char = 8'h50;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        exp_buf[{2'd2, 4'd4}]   = 8'h50;
        exp_dirty[{2'd2, 4'd4}] = 1'b1;
        wait_idle("flush with overlapping write");
        check("pending_cnt keeps rewritten cell", 32'(bus_if.pending_cnt), 1);
        model_flush();
        req(1'b0, 1'b0, 2'd0, 1'b1);
        wait_idle("resend flush");
        check("pending_cnt after resend", 32'(bus_if.pending_cnt), 0);

        // Driver never drops ready: commands finish on the ack timeout.
        stuck = 1'b1;
        host_write(2'd0, 4'd1, 8'h73);
        model_flush();
        req(1'b0, 1'b0, 2'd0, 1'b1);
        wait_pulse("stuck char", 1'b0, found);
        count_busy(n);
        check("stuck char busy cycles", n, ACK_TIMEOUT + 62);
        model_clear();
        req(1'b1, 1'b0, 2'd0, 1'b0);
        wait_pulse("stuck clear", 1'b1, found);
        count_busy(n);
        check("stuck clear busy cycles", n, ACK_TIMEOUT);
        check("stuck scoreboard drained", exp_q.size(), 0);
        stuck = 1'b0;

        // Reset during WAIT_DONE.
        host_write(2'd1, 4'd1, 8'h72);
        host_write(2'd3, 4'd3, 8'h74);
        model_flush();
        req(1'b0, 1'b0, 2'd0, 1'b1);
        wait_pulse("pre-reset char", 1'b0, found);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-command reset busy", 32'(bus_if.busy), 0);
        check("mid-command reset pending_cnt", 32'(bus_if.pending_cnt), 0);
        check("mid-command reset pulses", 32'({bus_if.drv_showchar, bus_if.drv_showbmp, bus_if.drv_clear}), 0);
        check("mid-command reset operands",
              32'({bus_if.drv_charval, bus_if.drv_row, bus_if.drv_col, bus_if.drv_bmp}), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_bmp(2'd1);
        model_flush();
        req(1'b0, 1'b1, 2'd1, 1'b1);
        wait_idle("post-reset blank redraw");
        check("post-reset pending_cnt", 32'(bus_if.pending_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
